// File: rtl/pomodoro_pkg.sv
// Shared definitions for the pomodoro sequencer.
//   phase_e      : phase encoding driven on the phase output
//   DEF_*        : default phase durations (minutes) and sessions per long break
//   BTN_*        : bit positions of the buttons in the internal button vector
//   to_min7      : narrows a minutes parameter to the 7-bit load_min field
package pomodoro_pkg;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'b00,
      PH_WORK  = 2'b01,
      PH_SHORT = 2'b10,
      PH_LONG  = 2'b11
   } phase_e;

   localparam int DEF_WORK_MIN  = 25;
   localparam int DEF_SHORT_MIN = 5;
   localparam int DEF_LONG_MIN  = 15;
   localparam int DEF_SESSIONS  = 4;

   localparam int NUM_BTN   = 3;
   localparam int BTN_START = 0;
   localparam int BTN_SKIP  = 1;
   localparam int BTN_ABORT = 2;

   function automatic logic [6:0] to_min7(input int m);
      return m[6:0];
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for one synchronized button level.
//   clk   : system clock
//   reset : synchronous, active-low; clears the history flop
//   level : button level
//   rise  : high in the cycle where level=1 and the previous sample was 0
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk) begin
      if (!reset) prev <= 1'b0;
      else        prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/pomodoro_sequencer.sv
// Pomodoro phase sequencer: walks WORK -> SHORT_BRK ... -> LONG_BRK -> WORK,
// and drives load/run to an external countdown timer.
//   clk, reset          : system clock, synchronous active-low reset
//   start_btn           : rising edge = start (IDLE) or pause/resume
//   skip_btn            : rising edge = end current phase early
//   abort_btn           : rising edge = return to IDLE
//   auto_advance        : run level applied after a phase change
//   timer_done          : one-cycle pulse when the countdown hits 00:00
//   load, load_min/sec  : one-cycle load strobe and value for the countdown
//   run                 : countdown enable level
//   phase               : current phase (pomodoro_pkg::phase_e)
//   session_cnt         : work sessions completed in the current cycle
//   alert               : one-cycle pulse on natural phase completion
module pomodoro_sequencer
   import pomodoro_pkg::*;
#(
   parameter int WORK_MIN  = DEF_WORK_MIN,
   parameter int SHORT_MIN = DEF_SHORT_MIN,
   parameter int LONG_MIN  = DEF_LONG_MIN,
   parameter int SESSIONS  = DEF_SESSIONS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       skip_btn,
   input  logic       abort_btn,
   input  logic       auto_advance,
   input  logic       timer_done,
   output logic       load,
   output logic [6:0] load_min,
   output logic [6:0] load_sec,
   output logic       run,
   output logic [1:0] phase,
   output logic [2:0] session_cnt,
   output logic       alert
);

   localparam logic [6:0] WORK_LD  = to_min7(WORK_MIN);
   localparam logic [6:0] SHORT_LD = to_min7(SHORT_MIN);
   localparam logic [6:0] LONG_LD  = to_min7(LONG_MIN);
   localparam logic [2:0] SESS_N   = 3'(SESSIONS);

   // ---------------- button edge detection ----------------
   logic [NUM_BTN-1:0] btn_lvl, btn_rise;
   assign btn_lvl = {abort_btn, skip_btn, start_btn};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      rise_detect u_rd (
         .clk   (clk),
         .reset (reset),
         .level (btn_lvl[i]),
         .rise  (btn_rise[i])
      );
   end

   // History flops clear to 0 in reset, so a button held through reset
   // release would look like a fresh edge. The first cycle after release
   // only primes the history; events are masked until armed is set.
   logic armed;
   always_ff @(posedge clk) begin
      if (!reset) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   logic ev_start, ev_skip, ev_abort;
   assign ev_start = armed & btn_rise[BTN_START];
   assign ev_skip  = armed & btn_rise[BTN_SKIP];
   assign ev_abort = armed & btn_rise[BTN_ABORT];

   // ---------------- state / output registers ----------------
   phase_e     phase_q, phase_d;
   logic       run_q, run_d;
   logic       load_q, load_d;
   logic [6:0] load_min_q, load_min_d;
   logic [2:0] sess_q, sess_d;
   logic       alert_q, alert_d;
   logic [2:0] sess_inc;

   assign sess_inc = sess_q + 3'd1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q    <= PH_IDLE;
         run_q      <= 1'b0;
         load_q     <= 1'b0;
         load_min_q <= '0;
         sess_q     <= '0;
         alert_q    <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         run_q      <= run_d;
         load_q     <= load_d;
         load_min_q <= load_min_d;
         sess_q     <= sess_d;
         alert_q    <= alert_d;
      end
   end

   // Priority: abort > timer_done > skip > start. A losing event is dropped.
   // Phase-changing events are also dropped in the cycle right after a load,
   // which keeps load from ever pulsing twice back to back (a freshly loaded
   // timer cannot legitimately complete on the very next cycle).
   always_comb begin
      phase_d    = phase_q;
      run_d      = run_q;
      load_d     = 1'b0;
      load_min_d = load_min_q;
      sess_d     = sess_q;
      alert_d    = 1'b0;

      if (ev_abort) begin
         phase_d = PH_IDLE;
         run_d   = 1'b0;
         sess_d  = '0;
      end else if (phase_q == PH_IDLE) begin
         // skip and timer_done mean nothing in IDLE; only start acts here
         if (ev_start && !load_q) begin
            phase_d    = PH_WORK;
            load_d     = 1'b1;
            load_min_d = WORK_LD;
            run_d      = 1'b1;
         end
      end else if (timer_done) begin
         // honoured even while paused: the last tick may race a pause
         if (!load_q) begin
            load_d  = 1'b1;
            alert_d = 1'b1;
            run_d   = auto_advance;
            if (phase_q == PH_WORK) begin
               if (sess_inc == SESS_N) begin
                  phase_d    = PH_LONG;
                  load_min_d = LONG_LD;
                  sess_d     = '0;
               end else begin
                  phase_d    = PH_SHORT;
                  load_min_d = SHORT_LD;
                  sess_d     = sess_inc;
               end
            end else begin
               phase_d    = PH_WORK;
               load_min_d = WORK_LD;
            end
         end
      end else if (ev_skip) begin
         // skipped work never counts and never earns the long break
         if (!load_q) begin
            load_d = 1'b1;
            run_d  = auto_advance;
            if (phase_q == PH_WORK) begin
               phase_d    = PH_SHORT;
               load_min_d = SHORT_LD;
            end else begin
               phase_d    = PH_WORK;
               load_min_d = WORK_LD;
            end
         end
      end else if (ev_start) begin
         run_d = ~run_q;
      end
   end

   assign load        = load_q;
   assign load_min    = load_min_q;
   assign load_sec    = 7'd0;
   assign run         = run_q;
   assign phase       = phase_q;
   assign session_cnt = sess_q;
   assign alert       = alert_q;

endmodule

// File: tb/tb_pomodoro_sequencer.sv
// Directed bench for pomodoro_sequencer (default parameters 25/5/15/4).
// Each step drives one cycle of inputs and pushes the outputs expected after
// that clock edge onto a scoreboard queue; they are popped and compared #1
// after the edge.
module tb_pomodoro_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start_btn = 1'b0, skip_btn = 1'b0, abort_btn = 1'b0;
   logic       auto_advance = 1'b1, timer_done = 1'b0;
   logic       load, run, alert;
   logic [6:0] load_min, load_sec;
   logic [1:0] phase;
   logic [2:0] session_cnt;

   int checks = 0;
   int failures = 0;
   int step_no = 0;

   typedef struct {
      logic       ld;
      logic [6:0] mn;
      logic       rn;
      logic [1:0] ph;
      logic [2:0] s;
      logic       al;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pomodoro_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start_btn    (start_btn),
      .skip_btn     (skip_btn),
      .abort_btn    (abort_btn),
      .auto_advance (auto_advance),
      .timer_done   (timer_done),
      .load         (load),
      .load_min     (load_min),
      .load_sec     (load_sec),
      .run          (run),
      .phase        (phase),
      .session_cnt  (session_cnt),
      .alert        (alert)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL step%0d.%s observed=%0d expected=%0d", step_no, tag, obs, expv);
      end
   endtask

   // inputs: rst st sk ab td aa ; expected after edge: load min run phase sess alert
   task automatic step(input logic rs, st, sk, ab, td, aa,
                       input logic ld, input logic [6:0] mn, input logic rn,
                       input logic [1:0] ph, input logic [2:0] s, input logic al);
      exp_t e;
      @(negedge clk);
      reset = rs; start_btn = st; skip_btn = sk; abort_btn = ab;
      timer_done = td; auto_advance = aa;
      e.ld = ld; e.mn = mn; e.rn = rn; e.ph = ph; e.s = s; e.al = al;
      sb.push_back(e);
      @(posedge clk);
      #1;
      step_no++;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL step%0d.scoreboard observed=empty expected=entry", step_no);
      end else begin
         e = sb.pop_front();
         chk("load",     {7'd0, load},        {7'd0, e.ld});
         chk("load_min", {1'b0, load_min},    {1'b0, e.mn});
         chk("load_sec", {1'b0, load_sec},    8'd0);
         chk("run",      {7'd0, run},         {7'd0, e.rn});
         chk("phase",    {6'd0, phase},       {6'd0, e.ph});
         chk("sess",     {5'd0, session_cnt}, {5'd0, e.s});
         chk("alert",    {7'd0, alert},       {7'd0, e.al});
      end
   endtask

   initial begin
      //    rs st sk ab td aa   ld mn  rn ph     s  al
      // reset held with start held high
      step(0, 1, 0, 0, 0, 1,   0, 0,  0, 2'd0, 0, 0);
      step(0, 1, 0, 0, 0, 1,   0, 0,  0, 2'd0, 0, 0);
      // release with start still high: no event
      step(1, 1, 0, 0, 0, 1,   0, 0,  0, 2'd0, 0, 0);
      step(1, 0, 0, 0, 0, 1,   0, 0,  0, 2'd0, 0, 0);
      // start -> WORK, load 25, run
      step(1, 1, 0, 0, 0, 1,   1, 25, 1, 2'd1, 0, 0);
      step(1, 0, 0, 0, 0, 1,   0, 25, 1, 2'd1, 0, 0);
      // four work sessions with breaks
      step(1, 0, 0, 0, 1, 1,   1, 5,  1, 2'd2, 1, 1);
      step(1, 0, 0, 0, 0, 1,   0, 5,  1, 2'd2, 1, 0);
      step(1, 0, 0, 0, 1, 1,   1, 25, 1, 2'd1, 1, 1);
      step(1, 0, 0, 0, 0, 1,   0, 25, 1, 2'd1, 1, 0);
      step(1, 0, 0, 0, 1, 1,   1, 5,  1, 2'd2, 2, 1);
      step(1, 0, 0, 0, 0, 1,   0, 5,  1, 2'd2, 2, 0);
      step(1, 0, 0, 0, 1, 1,   1, 25, 1, 2'd1, 2, 1);
      step(1, 0, 0, 0, 0, 1,   0, 25, 1, 2'd1, 2, 0);
      step(1, 0, 0, 0, 1, 1,   1, 5,  1, 2'd2, 3, 1);
      step(1, 0, 0, 0, 0, 1,   0, 5,  1, 2'd2, 3, 0);
      step(1, 0, 0, 0, 1, 1,   1, 25, 1, 2'd1, 3, 1);
      step(1, 0, 0, 0, 0, 1,   0, 25, 1, 2'd1, 3, 0);
      // timer_done + skip together at session 3 -> LONG, skip dropped
      step(1, 0, 1, 0, 1, 1,   1, 15, 1, 2'd3, 0, 1);
      step(1, 0, 0, 0, 0, 1,   0, 15, 1, 2'd3, 0, 0);
      // skip from LONG -> WORK, no alert
      step(1, 0, 1, 0, 0, 1,   1, 25, 1, 2'd1, 0, 0);
      step(1, 0, 0, 0, 0, 1,   0, 25, 1, 2'd1, 0, 0);
      // skip from WORK -> SHORT, count unchanged
      step(1, 0, 1, 0, 0, 1,   1, 5,  1, 2'd2, 0, 0);
      step(1, 0, 0, 0, 0, 1,   0, 5,  1, 2'd2, 0, 0);
      // auto_advance=0: SHORT done -> WORK paused
      step(1, 0, 0, 0, 1, 0,   1, 25, 0, 2'd1, 0, 1);
      step(1, 0, 0, 0, 0, 0,   0, 25, 0, 2'd1, 0, 0);
      // timer_done while paused is still honoured
      step(1, 0, 0, 0, 1, 0,   1, 5,  0, 2'd2, 1, 1);
      step(1, 0, 0, 0, 0, 0,   0, 5,  0, 2'd2, 1, 0);
      // start toggles run without load
      step(1, 1, 0, 0, 0, 0,   0, 5,  1, 2'd2, 1, 0);
      step(1, 0, 0, 0, 0, 0,   0, 5,  1, 2'd2, 1, 0);
      step(1, 1, 0, 0, 0, 0,   0, 5,  0, 2'd2, 1, 0);
      step(1, 0, 0, 0, 0, 0,   0, 5,  0, 2'd2, 1, 0);
      step(1, 1, 0, 0, 0, 1,   0, 5,  1, 2'd2, 1, 0);
      step(1, 0, 0, 0, 0, 1,   0, 5,  1, 2'd2, 1, 0);
      // reach SHORT with session 2
      step(1, 0, 0, 0, 1, 1,   1, 25, 1, 2'd1, 1, 1);
      step(1, 0, 0, 0, 0, 1,   0, 25, 1, 2'd1, 1, 0);
      step(1, 0, 0, 0, 1, 1,   1, 5,  1, 2'd2, 2, 1);
      step(1, 0, 0, 0, 0, 1,   0, 5,  1, 2'd2, 2, 0);
      // abort (with start in same cycle) -> IDLE, load_min held
      step(1, 1, 0, 1, 0, 1,   0, 5,  0, 2'd0, 0, 0);
      step(1, 0, 0, 0, 0, 1,   0, 5,  0, 2'd0, 0, 0);
      // timer_done and skip ignored in IDLE
      step(1, 0, 0, 0, 1, 1,   0, 5,  0, 2'd0, 0, 0);
      step(1, 0, 1, 0, 0, 1,   0, 5,  0, 2'd0, 0, 0);
      step(1, 0, 0, 0, 0, 1,   0, 5,  0, 2'd0, 0, 0);
      // restart, then reset mid-phase discards everything
      step(1, 1, 0, 0, 0, 1,   1, 25, 1, 2'd1, 0, 0);
      step(1, 0, 0, 0, 0, 1,   0, 25, 1, 2'd1, 0, 0);
      step(0, 0, 0, 0, 0, 1,   0, 0,  0, 2'd0, 0, 0);
      step(1, 0, 0, 0, 0, 1,   0, 0,  0, 2'd0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pomodoro_sequencer.md
POMODORO_SEQUENCER -- requirements
Module: pomodoro_sequencer

Interface
REQ-001 Parameter WORK_MIN, default 25: work-phase duration in minutes, range 1..99.
REQ-002 Parameter SHORT_MIN, default 5: short-break duration in minutes, range 1..99.
REQ-003 Parameter LONG_MIN, default 15: long-break duration in minutes, range 1..99.
REQ-004 Parameter SESSIONS, default 4: work sessions per long break, range 1..7.
REQ-005 clk  in  1: single system clock, 100 MHz.
REQ-006 reset  in  1: synchronous, active-low reset.
REQ-007 start_btn  in  1: synchronized button level; a rising edge means start, pause or resume.
REQ-008 skip_btn  in  1: synchronized button level; a rising edge ends the current phase early.
REQ-009 abort_btn  in  1: synchronized button level; a rising edge returns the block to idle.
REQ-010 auto_advance  in  1: 1 = the next phase runs automatically; 0 = the next phase loads paused.
REQ-011 timer_done  in  1: single-cycle pulse from the countdown timer when it reaches 00:00.
REQ-012 load  out  1: single-cycle pulse that loads load_min:load_sec into the countdown timer.
REQ-013 load_min  out  7: minutes value to load.
REQ-014 load_sec  out  7: seconds value to load; always 0.
REQ-015 run  out  1: level; the countdown decrements only while run=1.
REQ-016 phase  out  2: current phase; IDLE=00, WORK=01, SHORT_BRK=10, LONG_BRK=11.
REQ-017 session_cnt  out  3: number of completed work sessions in the current cycle.
REQ-018 alert  out  1: single-cycle pulse on natural phase completion, used to drive the RGB flag.

Function
REQ-019 Each button SHALL be edge-detected internally; the event is valid in the cycle where level=1 and the previous sample=0.
REQ-020 All outputs SHALL be registered and SHALL update on the clock edge after the triggering event (1-cycle latency).
REQ-021 Event priority per cycle SHALL be abort > timer_done > skip > start; lower-priority events in the same cycle are dropped, not queued.
REQ-022 In IDLE: start SHALL move to WORK with load=1, load_min=WORK_MIN, run=1; skip and timer_done SHALL be ignored.
REQ-023 In WORK, SHORT_BRK or LONG_BRK: start SHALL toggle run, with no load and no phase change.
REQ-024 A timer_done in WORK SHALL increment session_cnt. If the incremented count equals SESSIONS: go to LONG_BRK, load LONG_MIN, clear session_cnt to 0. Otherwise: go to SHORT_BRK and load SHORT_MIN.
REQ-025 A timer_done in SHORT_BRK or LONG_BRK SHALL move to WORK and load WORK_MIN; session_cnt is unchanged.
REQ-026 On any timer_done transition, alert=1 for one cycle and run=auto_advance.
REQ-027 Skip SHALL perform the same phase transition and load as timer_done, except: alert stays 0, session_cnt is not incremented, and skip from WORK always goes to SHORT_BRK.
REQ-028 A timer_done arriving while run=0 SHALL still be honoured (the timer may complete on its last tick as a pause is pressed).
REQ-029 Abort from any state SHALL give phase=IDLE, run=0, session_cnt=0, with no load and no alert.
REQ-030 load SHALL never be high in two consecutive cycles; load_min SHALL be held stable until the next load.

Reset
REQ-031 While reset=0 at a clk edge: phase=IDLE, run=0, load=0, load_min=0, load_sec=0, session_cnt=0, alert=0, and button history registers=0.
REQ-032 A reset mid-phase SHALL discard all progress; a button held high through reset release SHALL NOT produce an event.

Structure
REQ-033 The phase encoding and the default durations SHALL live in the shared package pomodoro_pkg.
REQ-034 A sub-module rise_detect (one flop plus an AND gate) SHALL be instantiated once per button.

Verification
REQ-035 Reset, then start edge -> one cycle later phase=01, load=1, load_min=25, run=1.
REQ-036 Four WORK timer_done pulses with intervening break timer_done pulses -> phases go 01,10,01,10,01,10,01,11 and session_cnt reads 0 after the fourth.
REQ-037 auto_advance=0, timer_done in WORK -> phase=10, alert=1 for one cycle, run=0; a start edge then gives run=1.
REQ-038 timer_done and skip_btn edge in the same cycle while in WORK with session_cnt=3 -> LONG_BRK, load_min=15, alert=1; the skip is dropped.
REQ-039 Abort edge during SHORT_BRK with session_cnt=2 -> next cycle phase=00, run=0, session_cnt=0, load=0.
